// File: rtl/decimate_pkg.sv
// rtl/decimate_pkg.sv - shared width derivations and mode encodings for the boxcar decimator
package decimate_pkg;

    localparam logic MODE_SUM  = 1'b0;
    localparam logic MODE_MEAN = 1'b1;

    // Accumulator holds 2^MAX full-scale samples without wrapping.
    function automatic int acc_width(input int input_width, input int max_log2);
        return input_width + max_log2;
    endfunction

    function automatic int output_width(input int input_width, input int max_log2, input int drop_lsb);
        return input_width + max_log2 - drop_lsb;
    endfunction

endpackage

// File: rtl/decimate_multi_if.sv
// rtl/decimate_multi_if.sv - sample/result bundle between ADC path and decimator
interface decimate_multi_if
    import decimate_pkg::*;
#(
    parameter int INPUT_WIDTH         = 14,
    parameter int N_CHANNELS          = 2,
    parameter int MAX_LOG2_DECIMATION = 8,
    parameter int DROP_LSB            = 1,
    parameter int LW                  = $clog2(MAX_LOG2_DECIMATION + 1),
    parameter int OUTPUT_WIDTH        = output_width(INPUT_WIDTH, MAX_LOG2_DECIMATION, DROP_LSB)
);
    logic [N_CHANNELS*INPUT_WIDTH-1:0]  data_i;
    logic                               valid_i;
    logic [LW-1:0]                      log2_dec_i;
    logic                               mode_i;
    logic [N_CHANNELS*OUTPUT_WIDTH-1:0] data_o;
    logic                               valid_o;

    modport master (
        output data_i, valid_i, log2_dec_i, mode_i,
        input  data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, log2_dec_i, mode_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/decimate_channel.sv
// rtl/decimate_channel.sv - one channel accumulator with sum/mean output scaling
module decimate_channel
    import decimate_pkg::*;
#(
    parameter int INPUT_WIDTH         = 14,
    parameter int MAX_LOG2_DECIMATION = 8,
    parameter int DROP_LSB            = 1,
    parameter int LW                  = $clog2(MAX_LOG2_DECIMATION + 1),
    localparam int OUTPUT_WIDTH       = output_width(INPUT_WIDTH, MAX_LOG2_DECIMATION, DROP_LSB)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic signed [INPUT_WIDTH-1:0]  sample_i,
    input  logic                           acc_en_i,
    input  logic                           dump_en_i,
    input  logic [LW-1:0]                  l_i,
    input  logic                           mode_i,
    output logic signed [OUTPUT_WIDTH-1:0] data_o
);
    localparam int AW = acc_width(INPUT_WIDTH, MAX_LOG2_DECIMATION);

    logic signed [AW-1:0]           acc_q, acc_d;
    logic signed [OUTPUT_WIDTH-1:0] data_q, data_d;
    logic signed [AW-1:0]           sample_ext;
    logic signed [AW-1:0]           total;
    logic signed [AW-1:0]           shifted;

    // Accumulate, or on the frame's last sample fold it in and dump the scaled total.
    always_comb begin
        sample_ext = {{MAX_LOG2_DECIMATION{sample_i[INPUT_WIDTH-1]}}, sample_i};
        total      = acc_q + sample_ext;
        shifted    = total;
        acc_d      = acc_q;
        data_d     = data_q;
        if (dump_en_i) begin
            acc_d = '0;
            if (mode_i == MODE_MEAN) begin
                shifted = total >>> l_i;
            end else begin
                shifted = total >>> DROP_LSB;
            end
            // Both scalings fit OUTPUT_WIDTH, so dropping the upper bits loses only sign copies.
            data_d = shifted[OUTPUT_WIDTH-1:0];
        end else if (acc_en_i) begin
            acc_d = total;
        end
    end

    // Accumulator and held result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/decimate_multi.sv
// rtl/decimate_multi.sv - multi-channel accumulate-and-dump decimator with runtime factor
module decimate_multi
    import decimate_pkg::*;
#(
    parameter int INPUT_WIDTH         = 14,
    parameter int N_CHANNELS          = 2,
    parameter int MAX_LOG2_DECIMATION = 8,
    parameter int DROP_LSB            = 1,
    localparam int LW                 = $clog2(MAX_LOG2_DECIMATION + 1),
    localparam int OUTPUT_WIDTH       = output_width(INPUT_WIDTH, MAX_LOG2_DECIMATION, DROP_LSB)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    decimate_multi_if.slave  bus
);
    localparam int ML = MAX_LOG2_DECIMATION;

    logic [ML-1:0] cnt_q, cnt_d;
    logic [LW-1:0] l_q, l_d;
    logic          mode_q, mode_d;
    logic          valid_q, valid_d;
    logic [LW-1:0] l_clamp;
    logic [ML:0]   frame_last;
    logic          is_last;
    logic          acc_en;
    logic          dump_en;

    logic [N_CHANNELS-1:0][OUTPUT_WIDTH-1:0] ch_data;

    // Frame counter, L/mode latch at frame boundaries, and the one-cycle result strobe.
    always_comb begin
        l_clamp    = (bus.log2_dec_i > LW'(ML)) ? LW'(ML) : bus.log2_dec_i;
        frame_last = ((ML+1)'(1) << l_q) - (ML+1)'(1);
        is_last    = ({1'b0, cnt_q} == frame_last);
        acc_en     = bus.valid_i && !is_last;
        dump_en    = bus.valid_i && is_last;

        cnt_d   = cnt_q;
        l_d     = l_q;
        mode_d  = mode_q;
        valid_d = dump_en;
        if (dump_en) begin
            cnt_d  = '0;
            l_d    = l_clamp;
            mode_d = bus.mode_i;
        end else if (acc_en) begin
            cnt_d = cnt_q + ML'(1);
        end
    end

    // Control registers; reset picks up the requested L and mode so the first frame uses them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            l_q     <= l_clamp;
            mode_q  <= bus.mode_i;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
        decimate_channel #(
            .INPUT_WIDTH         (INPUT_WIDTH),
            .MAX_LOG2_DECIMATION (MAX_LOG2_DECIMATION),
            .DROP_LSB            (DROP_LSB),
            .LW                  (LW)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .sample_i  (bus.data_i[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .acc_en_i  (acc_en),
            .dump_en_i (dump_en),
            .l_i       (l_q),
            .mode_i    (mode_q),
            .data_o    (ch_data[k])
        );
    end

    assign bus.data_o  = ch_data;
    assign bus.valid_o = valid_q;
endmodule

// File: doc/decimate_multi.md
Name: decimate_multi

Overview:
- Multi-channel boxcar (accumulate-and-dump) decimator; successor to the single-channel fixed-factor decimator.
- Adds N parallel channels, a runtime-selectable decimation factor, an input valid strobe and a sum/mean output mode.
- Sits between the ADC sample path and the slower feedback/readout logic; valid_o is the downstream clock enable.

Parameters:
- INPUT_WIDTH, 14, signed sample width per channel.
- N_CHANNELS, 2, number of parallel channels sharing one frame counter.
- MAX_LOG2_DECIMATION, 8, largest supported log2 of the decimation factor.
- DROP_LSB, 1, LSBs discarded from the full sum in sum mode.
- Derived: OUTPUT_WIDTH = INPUT_WIDTH + MAX_LOG2_DECIMATION - DROP_LSB.
- Derived: LW = $clog2(MAX_LOG2_DECIMATION+1).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- data_i  in  N_CHANNELS*INPUT_WIDTH  packed signed samples; channel k is at [k*INPUT_WIDTH +: INPUT_WIDTH].
- valid_i  in  1  data_i holds a new sample this cycle.
- log2_dec_i  in  LW  requested log2 decimation factor L.
- mode_i  in  1  0 = sum (shifted by DROP_LSB), 1 = mean (shifted by L).
- data_o  out  N_CHANNELS*OUTPUT_WIDTH  packed signed decimated results.
- valid_o  out  1  one-cycle pulse: data_o updated.

Behaviour:
- Reset is synchronous: rst_i high at a rising edge clears the accumulators, the frame counter and data_o to 0, clears valid_o to 0, and sets the latched L and mode to the current input values.
- Reset mid-frame discards the partial sums; the next valid_i sample starts a new frame.
- Accumulators are signed, width INPUT_WIDTH+MAX_LOG2_DECIMATION. Full-scale input cannot overflow at any L ≤ MAX.
- L and mode are latched only at the start of a frame: at reset, and on the cycle a frame completes. Input changes mid-frame take effect from the next frame.
- log2_dec_i > MAX_LOG2_DECIMATION is clamped to MAX_LOG2_DECIMATION at latch time.
- Cycles with valid_i = 0 leave all state unchanged, so gaps inside a frame are allowed.
- Each valid_i cycle with counter < 2^L - 1: acc += sample, counter += 1.
- Valid_i cycle with counter == 2^L - 1 (frame completes):
  - total = acc + sample.
  - Sum mode: data_o = total >>> DROP_LSB (arithmetic shift).
  - Mean mode: data_o = total >>> L (arithmetic shift, floor), sign-extended to OUTPUT_WIDTH.
  - valid_o = 1 on the following cycle.
  - acc = 0, counter = 0, and the new L and mode are latched from the inputs.
- Latency: valid_o is high exactly one clock after the valid_i that completes the frame. It is high for one cycle only; otherwise valid_o = 0.
- data_o holds its value between pulses.
- L = 0: every valid sample is a full frame. Output = sample >>> DROP_LSB (sum mode) or sample (mean mode), with latency 1.
- Back-to-back frames with valid_i held high give continuous output with no dead cycles. valid_o rate = valid_i rate / 2^L.
- All channels share the counter and valid_o, and complete their frames in the same cycle.

Decomposition:
- Package decimate_pkg holds:
  - The OUTPUT_WIDTH and accumulator-width derivations as constant functions.
  - MODE_SUM = 1'b0 and MODE_MEAN = 1'b1.
- Sub-module decimate_channel, one instance per channel:
  - Holds the accumulator and the output shift/extend for one channel.
  - Inputs: sample, accumulate enable, dump enable, latched L, latched mode.
- The top level holds the frame counter, the L/mode latch, the L clamp and the valid_o register.

Test Plan:
- Defaults, L=4, sum mode, constant 100 with valid_i high -> every 16th cycle data_o ch0 = 800; valid_o pulses once per 16 samples.
- L=4, mean mode, ch0 = -100, ch1 = 300 -> data_o ch0 = -100, ch1 = 300. Ch0 = -7 alone -> -7 (floor of -112/16).
- L=8, sum mode, ch0 = -8192 (full scale) -> data_o = -1048576 (21-bit minimum), no wrap. Ch0 = 8191 -> 1048448.
- L=2, constant 10, valid_i high every third cycle -> valid_o one cycle after the 4th accepted sample, data_o = 20. No pulse during gaps.
- Frame running at L=4 when log2_dec_i changes to 1 after 5 samples -> current frame still takes 16 samples. Following frames take 2 samples; with input 50, output = 50. log2_dec_i = 15 -> behaves as L=8.
- rst_i pulsed for one cycle after 7 samples of 100 at L=3 -> data_o = 0, valid_o = 0. Next output appears after 8 fresh samples and equals 400. L=0 with input -3 -> data_o = -2 (sum mode, floor), latency 1.
